hex2ascii_tx: RTL
=================

# hex2ascii_tx

Serialises a captured binary word into ASCII hexadecimal characters, most-significant nibble first, for a byte-wide UART transmitter; this is the transmit-side counterpart of the ASCII-hex-to-nibble receive path in the temperature-monitor design. A word is accepted only when the block is idle. Each character is issued as a single-cycle valid pulse, paced by the transmitter's ready signal.

## Interface

- NIBBLES, 4: hex digits per word; the input word width is 4*NIBBLES.
- UPCASE, 1: 1 emits 'A'..'F' (0x41..0x46); 0 emits 'a'..'f' (0x61..0x66).
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- din  input  4*NIBBLES  word to transmit.
- din_vld  input  1  din valid; accepted only when busy==0.
- busy  output  1  word in progress; new words are ignored while high.
- tx_rdy  input  1  UART transmitter can take a byte.
- dout  output  8  ASCII character, registered.
- dout_vld  output  1  one-cycle pulse; dout is valid in this cycle.

## Operation

- States:
  - IDLE: busy=0. din_vld=1 captures din into a shift register, loads the nibble counter with NIBBLES-1, and moves to SEND.
  - SEND: issues one character per "issue event".
    - After the last nibble, the next state is IDLE, or CR when HEX2ASCII_CRLF_EN is set.
  - CR: issues 0x0D, then moves to LF.
  - LF: issues 0x0A, then moves to IDLE.
- Issue event: in a non-IDLE state, tx_rdy==1 and dout_vld==0 at the clock edge.
  - The dout_vld==0 condition enforces a mandatory one-cycle gap, so a transmitter that drops tx_rdy one cycle late cannot receive a byte twice.
- Nibble mapping:
  - 0..9 maps to nibble+0x30.
  - 10..15 maps to nibble+0x37 (UPCASE=1) or nibble+0x57 (UPCASE=0).
  - The arithmetic is 8-bit with no overflow possible.
- After each issue the shift register shifts left by 4, and the top nibble is always the next one to send.
- dout holds the last issued character between pulses.
- din_vld while busy==1 is dropped; there is no buffering and no error flag.
- din_vld==0 in IDLE leaves everything unchanged.
- Reset at any time returns to IDLE and discards any partial word; no further characters are issued.
- Reset values: busy=0, dout=8'h00, dout_vld=0, state=IDLE, shift register=0, nibble counter=0.

## Timing

- Capture at edge E0 (IDLE, din_vld=1). busy=1 from E0.
- With tx_rdy held at 1, characters issue at edges E1, E3, E5, ... E(2*NIBBLES-1). dout_vld is high for the single cycle after each of these edges.
- First-character latency is one edge after capture. Maximum throughput is one character per 2 cycles.
- tx_rdy low stalls the block in its current state with no issue. The issue happens on the first edge where tx_rdy==1 and dout_vld==0.
- busy clears on the edge that issues the final character (last nibble, or LF with CRLF enabled).
  - In that cycle dout_vld=1 and busy=0, so a new word may be captured on the next edge.
  - The first character of the new word then issues no earlier than the following edge, because the gap rule still applies.
- Total cycles per word with tx_rdy=1: 2*NIBBLES-1 from capture to last pulse, or 2*NIBBLES+3 with CRLF.

## Configuration

- HEX2ASCII_CRLF_EN:
  - Defined: the CR and LF states are compiled in, and each word is followed by 0x0D then 0x0A under the same pacing and gap rules.
  - Undefined: the CR and LF states are absent, and exactly NIBBLES characters are emitted per word.

## Test plan

- Basic word: NIBBLES=4, UPCASE=1, tx_rdy=1, din=16'h1A9F with a single din_vld pulse → dout 0x31, 0x41, 0x39, 0x46 at edges E1/E3/E5/E7; busy falls at E7.
- Lowercase and CRLF: UPCASE=0 with HEX2ASCII_CRLF_EN defined, din=16'hBEEF → 0x62, 0x65, 0x65, 0x66, 0x0D, 0x0A; busy falls with the 0x0A pulse.
- Backpressure: din=16'h0F0F with tx_rdy held low 5 cycles after the first pulse → no dout_vld during the stall; 0x46 issues on the first edge with tx_rdy=1; exactly 4 pulses total.
- Busy drop: din_vld=1 with din=16'h2222 two cycles after capturing 16'h1111 → output is 0x31 ×4 only, and the 0x2222 word never appears.
- Boundaries and back-to-back: din=16'h0000 then 16'hFFFF, with din_vld asserted in the cycle busy falls → 0x30 ×4 followed by 0x46 ×4, with no lost or duplicated character.
- Reset mid-word: rst_n low after the second character of 16'h1234 → busy=0, dout=0x00, dout_vld=0 immediately; no further pulses until a new capture.

Source files
------------

// File: rtl/hex2ascii_tx.sv
// -----------------------------------------------------------------------------
// hex2ascii_tx
//   Serialises a captured binary word into ASCII hex characters, MS nibble
//   first, for a byte-wide UART transmitter. A word is captured only while
//   idle. Each character is a single-cycle dout_vld pulse paced by tx_rdy,
//   with a mandatory one-cycle gap between pulses.
//
//   Optional feature macro: HEX2ASCII_CRLF_EN
//     defined   -> every word is followed by 0x0D, 0x0A
//     undefined -> exactly NIBBLES characters per word
//
// Parameters
//   NIBBLES  hex digits per word (din is 4*NIBBLES bits)
//   UPCASE   1: 'A'..'F', 0: 'a'..'f'
// Ports
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   din       word to transmit
//   din_vld   din valid, honoured only when busy==0
//   busy      word in progress
//   tx_rdy    transmitter can accept a byte
//   dout      ASCII character (registered, holds between pulses)
//   dout_vld  one-cycle pulse qualifying dout
// -----------------------------------------------------------------------------
module hex2ascii_tx #(
  parameter int NIBBLES = 4,
  parameter bit UPCASE  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4*NIBBLES-1:0] din,
  input  logic                 din_vld,
  output logic                 busy,
  input  logic                 tx_rdy,
  output logic [7:0]           dout,
  output logic                 dout_vld
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1
`ifdef HEX2ASCII_CRLF_EN
    ,
    S_CR   = 2'd2,
    S_LF   = 2'd3
`endif
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   shift_q, shift_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [7:0]     dout_q, dout_d;
  logic           dout_vld_q, dout_vld_d;
  logic           issue;

  function automatic logic [7:0] nib2asc(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return (UPCASE ? 8'h37 : 8'h57) + {4'h0, n};
  endfunction

  // Gating on !dout_vld_q forces a dead cycle after every pulse, so a
  // transmitter that drops tx_rdy one cycle late never sees a byte twice.
  assign issue = (state_q != S_IDLE) && tx_rdy && !dout_vld_q;

  // State register + datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      dout_q     <= 8'h00;
      dout_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (din_vld) state_d = S_SEND;
      S_SEND: begin
        if (issue && cnt_q == '0) begin
`ifdef HEX2ASCII_CRLF_EN
          state_d = S_CR;
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef HEX2ASCII_CRLF_EN
      S_CR:   if (issue) state_d = S_LF;
      S_LF:   if (issue) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    dout_d     = dout_q;
    dout_vld_d = issue;
    if (state_q == S_IDLE && din_vld) begin
      shift_d = din;
      cnt_d   = CW'(NIBBLES - 1);
    end
    if (issue) begin
      case (state_q)
        S_SEND: begin
          dout_d  = nib2asc(shift_q[W-1 -: 4]);
          shift_d = shift_q << 4;
          if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        end
`ifdef HEX2ASCII_CRLF_EN
        S_CR:    dout_d = 8'h0D;
        S_LF:    dout_d = 8'h0A;
`endif
        default: dout_d = dout_q;
      endcase
    end
  end

  // Outputs
  always_comb begin
    busy     = (state_q != S_IDLE);
    dout     = dout_q;
    dout_vld = dout_vld_q;
  end

endmodule
